rv_rf_mp: RTL and testbench

Parametrised multi-port integer register file for the RV core. It supports N read ports, M write ports and configurable XLEN/depth. x0 is hardwired to zero. Reads are registered with an optional write-to-read bypass, and a per-register busy scoreboard supports the issue/writeback stages. It sits between decode (read/issue) and writeback (write), replacing the fixed 2R1W 64-bit file.

---
 rtl/rv_rf_mp.sv | 95 +++++++++
 tb/tb_rv_rf_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_rf_mp.sv
// Multi-port integer register file with hardwired x0, registered reads,
// optional write-to-read bypass and a per-register busy scoreboard.
module rv_rf_mp #(
    parameter int  XLEN   = 64,
    parameter int  NREGS  = 32,
    parameter int  NUM_RD = 2,
    parameter int  NUM_WR = 1,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic [NREGS-1:0]         busy_o
);

    logic [XLEN-1:0]  regs   [NREGS];
    logic [XLEN-1:0]  rd_sel [NUM_RD];
    logic [XLEN-1:0]  rd_q   [NUM_RD];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // NOTE: every variable an always_comb writes gets a default first, otherwise a latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_sel[i] = regs[rd_addr_i[i*AW +: AW]];
            if (BYPASS) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[i*AW +: AW]))
                        rd_sel[i] = wr_data_i[j*XLEN +: XLEN];
                end
            end
            if (rd_addr_i[i*AW +: AW] == '0)
                rd_sel[i] = '0;
        end
    end

    // Writes clear first, then the issue sets, so a same-cycle issue keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j])
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
        end
        if (iss_en_i)
            busy_d[iss_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: the register array is reset on purpose (reads after reset must return 0),
    // which rules out mapping it onto an SRAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            // NOTE: non-blocking assignments in port order; the last one scheduled
            // (highest port index) wins a same-address conflict.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0))
                    regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++)
                rd_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en_i[i])
                    rd_q[i] <= rd_sel[i];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++)
            rd_data_o[i*XLEN +: XLEN] = rd_q[i];
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_rv_rf_mp.sv
// Bench for rv_rf_mp: a bypass and a non-bypass 2R2W instance share stimulus and
// are checked every cycle against a register-level model, plus directed cases.
module tb_rv_rf_mp;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_RD-1:0]      rd_en = '0;
    logic [NUM_RD*AW-1:0]   rd_addr = '0;
    logic [NUM_WR-1:0]      wr_en = '0;
    logic [NUM_WR*AW-1:0]   wr_addr = '0;
    logic [NUM_WR*XLEN-1:0] wr_data = '0;
    logic                   iss_en = 1'b0;
    logic [AW-1:0]          iss_addr = '0;
    logic [NUM_RD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NREGS-1:0]       busy_b, busy_n;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    rv_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_o(busy_b)
    );

    rv_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_o(busy_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: architectural state before/after each edge; bypass reads see "after",
    // non-bypass reads see "before"; x0 is simply never written.
    logic [63:0] m_mem   [NREGS];
    logic [63:0] m_after [NREGS];
    logic [31:0] m_busy;
    logic [63:0] exp_b [NUM_RD];
    logic [63:0] exp_n [NUM_RD];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            for (int i = 0; i < NUM_RD; i++) begin
                exp_b[i] = '0;
                exp_n[i] = '0;
            end
            m_busy = '0;
        end else begin
            m_after = m_mem;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                    m_after[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                    m_busy[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en) m_busy[iss_addr] = 1'b1;
            m_busy[0] = 1'b0;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    exp_b[i] = m_after[rd_addr[i*AW +: AW]];
                    exp_n[i] = m_mem[rd_addr[i*AW +: AW]];
                end
            end
            m_mem = m_after;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            for (int i = 0; i < NUM_RD; i++) begin
                check("rd_bypass", rd_data_b[i*XLEN +: XLEN], exp_b[i]);
                check("rd_nobypass", rd_data_n[i*XLEN +: XLEN], exp_n[i]);
            end
            check("busy_bypass", {32'h0, busy_b}, {32'h0, m_busy});
            check("busy_nobypass", {32'h0, busy_n}, {32'h0, m_busy});
        end
    end

    task automatic idle();
        rd_en = '0; wr_en = '0; iss_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [63:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_iss(input int a);
        iss_en = 1'b1;
        iss_addr = AW'(a);
    endtask

    initial begin
        #1;
        check("reset_rd_b0", rd_data_b[63:0], 64'h0);
        check("reset_busy_b", {32'h0, busy_b}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset in mid-operation
        set_wr(0, 5, 64'hDEAD); set_iss(5);
        @(negedge clk); idle();
        set_rd(0, 5);
        @(negedge clk);
        check("x5_before_reset", rd_data_b[63:0], 64'hDEAD);
        check("busy5_before_reset", {32'h0, busy_b}, 64'h20);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd_b", rd_data_b[63:0], 64'h0);
        check("async_rst_rd_n", rd_data_n[63:0], 64'h0);
        check("async_rst_busy", {32'h0, busy_b}, 64'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("x5_after_reset", rd_data_b[63:0], 64'h0);

        // x0 hardwired
        idle();
        set_wr(0, 0, 64'hFFFF_FFFF_FFFF_FFFF); set_rd(0, 0); set_rd(1, 0); set_iss(0);
        @(negedge clk); idle();
        check("x0_rd_b", rd_data_b[63:0], 64'h0);
        check("x0_rd_n", rd_data_n[127:64], 64'h0);
        check("x0_busy", {32'h0, busy_b}, 64'h0);

        // Bypass vs read-before-write
        set_wr(0, 7, 64'h1234); set_rd(0, 7);
        @(negedge clk); idle();
        check("byp_x7", rd_data_b[63:0], 64'h1234);
        check("nobyp_x7_old", rd_data_n[63:0], 64'h0);
        set_rd(0, 7);
        @(negedge clk); idle();
        check("nobyp_x7_new", rd_data_n[63:0], 64'h1234);

        // Write-port conflict
        set_wr(0, 3, 64'hA); set_wr(1, 3, 64'hB); set_rd(1, 3);
        @(negedge clk); idle();
        check("conflict_byp", rd_data_b[127:64], 64'hB);
        set_rd(0, 3);
        @(negedge clk); idle();
        check("conflict_stored", rd_data_n[63:0], 64'hB);

        // Scoreboard
        set_iss(9);
        @(negedge clk); idle();
        check("busy9_set", {63'h0, busy_b[9]}, 64'h1);
        set_iss(9); set_wr(1, 9, 64'h99);
        @(negedge clk); idle();
        check("busy9_iss_wins", {63'h0, busy_b[9]}, 64'h1);
        set_wr(1, 9, 64'h99);
        @(negedge clk); idle();
        check("busy9_clear", {63'h0, busy_b[9]}, 64'h0);

        // Read hold
        set_wr(0, 4, 64'h55); set_wr(1, 6, 64'h77);
        @(negedge clk); idle();
        set_rd(0, 4);
        @(negedge clk); idle();
        check("hold_load", rd_data_b[63:0], 64'h55);
        rd_addr[0 +: AW] = AW'(6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold", rd_data_b[63:0], 64'h55);
        end

        // Random traffic, addresses biased low so conflicts and bypasses occur
        for (int c = 0; c < 3000; c++) begin
            rd_en = NUM_RD'($urandom_range(0, 3));
            wr_en = NUM_WR'($urandom_range(0, 3));
            iss_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUM_RD; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int j = 0; j < NUM_WR; j++) begin
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
                wr_data[j*XLEN +: XLEN] = {$urandom, $urandom};
            end
            iss_addr = AW'($urandom_range(0, 7));
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
